// File: rtl/rca_operand_sequencer.sv
// rca_operand_sequencer: collects operands A and B from a byte stream, holds
// them on the ripple-carry adder inputs for a fixed settle time, then captures
// sum/carry-out and offers the result on a valid/ready output.
// Optional feature macro: RCA_CARRY_CHAIN_EN (carry chaining across transactions
// for little-endian multi-byte addition, adds the carry_clr input).
module rca_operand_sequencer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef RCA_CARRY_CHAIN_EN
  input  logic             carry_clr,
`endif
  output logic             busy
);

  // Settle counter wide enough for the full legal range 1..15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_SETTLE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   add_a_q, add_a_d;
  logic [WIDTH-1:0]   add_b_q, add_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_sum_q, out_sum_d;
  logic               out_cout_q, out_cout_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               in_xfer;
  logic               out_xfer;
`ifdef RCA_CARRY_CHAIN_EN
  logic               carry_q, carry_d;
`endif

  // in_ready is a registered copy of "state is LOAD_A or LOAD_B".
  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  // Next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_valid_d = out_valid_q;
`ifdef RCA_CARRY_CHAIN_EN
    carry_d     = carry_q;
`endif
    case (state_q)
      S_LOAD_A: begin
        if (in_xfer) begin
          add_a_d = in_data;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (in_xfer) begin
          add_b_d = in_data;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          out_sum_d   = add_sum;
          out_cout_d  = add_cout;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
`ifdef RCA_CARRY_CHAIN_EN
          carry_d     = add_cout;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (out_xfer) begin
          out_valid_d = 1'b0;
          state_d     = S_LOAD_A;
        end
      end
      default: state_d = S_LOAD_A;
    endcase
`ifdef RCA_CARRY_CHAIN_EN
    // A clear request in LOAD_A wins over any capture.
    if (state_q == S_LOAD_A && carry_clr) begin
      carry_d = 1'b0;
    end
`endif
    in_ready_d = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
    busy_d     = (state_d != S_LOAD_A);
  end

  // State and output registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD_A;
      add_a_q     <= '0;
      add_b_q     <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef RCA_CARRY_CHAIN_EN
      carry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef RCA_CARRY_CHAIN_EN
      carry_q     <= carry_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
`ifdef RCA_CARRY_CHAIN_EN
  assign add_cin   = carry_q;
`else
  assign add_cin   = 1'b0;
`endif

endmodule

// File: tb/tb_rca_operand_sequencer.sv
// Self-checking bench for rca_operand_sequencer: directed scenarios followed by
// randomized transactions checked against an arithmetic reference model.
module tb_rca_operand_sequencer;

  localparam int unsigned W = 8;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_sum;
  logic         add_cout;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
`ifdef RCA_CARRY_CHAIN_EN
  logic         carry_clr;
`endif

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int carry_m    = 0;

  rca_operand_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef RCA_CARRY_CHAIN_EN
    .carry_clr (carry_clr),
`endif
    .busy      (busy)
  );

  // Combinational ripple-carry adder stand-in.
  assign {add_cout, add_sum} = (W+1)'(add_a) + (W+1)'(add_b) + (W+1)'(add_cin);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transfer one byte; returns the edge count at which it was accepted.
  task automatic push(input logic [W-1:0] d, output int t);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    t        = cyc;
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  // Wait for and retire one result, checking it against the model values.
  task automatic pull(input logic [W-1:0] ea, input logic [W-1:0] eb,
                      input int t_b, input int stall);
    int       n = 0;
    int       tot;
    logic [W-1:0] es;
    logic     ec;
    out_ready = 1'b0;
    tot = int'(ea) + int'(eb) + carry_m;
    es  = W'(tot % 256);
    ec  = (tot >= 256);
`ifdef RCA_CARRY_CHAIN_EN
    carry_m = int'(ec);
`endif
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_wait", 32'(out_valid), 32'd1);
    if (t_b >= 0) chk("latency", 32'(cyc - t_b), 32'(S));
    chk("out_sum",  32'(out_sum),  32'(es));
    chk("out_cout", 32'(out_cout), 32'(ec));
    chk("add_a_hold", 32'(add_a), 32'(ea));
    chk("add_b_hold", 32'(add_b), 32'(eb));
    chk("in_ready_hold", 32'(in_ready), 32'd0);
    chk("busy_hold", 32'(busy), 32'd1);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      in_data  = W'($urandom);
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_sum",   32'(out_sum),   32'(es));
      chk("stall_ready", 32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("retired", 32'(out_valid), 32'd0);
    chk("load_a_ready", 32'(in_ready), 32'd1);
    chk("load_a_busy", 32'(busy), 32'd0);
    chk("operand_a_kept", 32'(add_a), 32'(ea));
  endtask

  initial begin
    int ta, tb;
    logic [W-1:0] ra, rb;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef RCA_CARRY_CHAIN_EN
    carry_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_add_b", 32'(add_b), 32'd0);
    chk("rst_cin", 32'(add_cin), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_cout", 32'(out_cout), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic add with back-to-back operands and latency check.
    push(8'h0F, ta);
    chk("load_b_busy", 32'(busy), 32'd1);
    push(8'h01, tb);
    chk("b_after_a", 32'(tb - ta), 32'd1);
    pull(8'h0F, 8'h01, tb, 0);

    // Overflow: carry-out only on out_cout; operands persist until next A.
    push(8'hFF, ta);
    push(8'h01, tb);
    pull(8'hFF, 8'h01, tb, 0);
    repeat (3) @(negedge clk);
    chk("idle_add_a", 32'(add_a), 32'hFF);
    chk("idle_add_b", 32'(add_b), 32'h01);
    push(8'h20, ta);
    chk("new_add_a", 32'(add_a), 32'h20);
    chk("old_add_b", 32'(add_b), 32'h01);
    // Gap of 3 idle cycles in LOAD_B.
    repeat (3) begin
      @(negedge clk);
      chk("gap_ready", 32'(in_ready), 32'd1);
      chk("gap_add_b", 32'(add_b), 32'h01);
    end
    push(8'h22, tb);
    pull(8'h20, 8'h22, tb, 0);

    // Backpressure for 6 cycles with junk in_valid ignored.
    push(8'hA5, ta);
    push(8'h5A, tb);
    pull(8'hA5, 8'h5A, tb, 6);

    // Reset during SETTLE discards the transaction immediately.
    push(8'hAA, ta);
    push(8'h55, tb);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_add_a", 32'(add_a), 32'd0);
    chk("arst_add_b", 32'(add_b), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_sum", 32'(out_sum), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    carry_m = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    push(8'h03, ta);
    push(8'h04, tb);
    pull(8'h03, 8'h04, tb, 0);

`ifdef RCA_CARRY_CHAIN_EN
    // Multi-byte carry chaining.
    carry_clr = 1'b1;
    @(negedge clk);
    carry_clr = 1'b0;
    carry_m   = 0;
    push(8'hFF, ta);
    push(8'h01, tb);
    pull(8'hFF, 8'h01, tb, 0);
    chk("chain_cin", 32'(add_cin), 32'd1);
    push(8'h00, ta);
    push(8'h00, tb);
    pull(8'h00, 8'h00, tb, 0);
    chk("chain_sum_01", 32'(out_sum), 32'h01);
    carry_clr = 1'b1;
    @(negedge clk);
    carry_clr = 1'b0;
    carry_m   = 0;
    push(8'h00, ta);
    push(8'h00, tb);
    pull(8'h00, 8'h00, tb, 0);
`endif

    // Randomized transactions with gaps, stalls and stray out_ready.
    for (int k = 0; k < 30; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      repeat ($urandom_range(0, 2)) begin
        out_ready = 1'($urandom);
        @(negedge clk);
      end
      out_ready = 1'($urandom);
      push(ra, ta);
      out_ready = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push(rb, tb);
      pull(ra, rb, tb, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
